fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL have parameter OPC_W, default 7, meaning opcode width.
REQ-002 The block SHALL have parameter HLT_OPC, default 7'b1100001, meaning halt opcode.
REQ-003 The block SHALL have parameter IMM_CLS, default 2'b01, meaning opcode[6:5] value marking two-word (immediate) instructions.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  OPC_W  opcode of word currently in IF/ID.
REQ-007 instr_valid  input  1  IF/ID holds a valid instruction.
REQ-008 mem_ready  input  1  instruction memory returns data this cycle.
REQ-009 stall_in  input  1  load-use hazard from decode.
REQ-010 branch_taken  input  1  redirect resolved in execute.
REQ-011 intr  input  1  level interrupt request.
REQ-012 pc_sel  output  2  0 PC+1, 1 branch target, 2 reset vector M[0], 3 interrupt vector M[1].
REQ-013 pc_en  output  1  PC register write enable.
REQ-014 ifid_en  output  1  IF/ID write enable.
REQ-015 ifid_flush  output  1  insert bubble into IF/ID.
REQ-016 imm_cycle  output  1  current fetch is the immediate word.
REQ-017 pc_save  output  1  push PC to interrupt save register.
REQ-018 intr_ack  output  1  one-cycle interrupt acknowledge.
REQ-019 halted  output  1  core halted.

Function
REQ-020 FSM states SHALL be BOOT, RUN, IMM, HALT, INT1, INT2; all outputs Moore/Mealy-decoded from state and registered inputs, no output latency beyond current cycle.
REQ-021 BOOT: pc_sel=2, ifid_flush=1, pc_en=mem_ready; BOOT->RUN when mem_ready=1, else remain.
REQ-022 RUN priority SHALL be branch_taken > stall_in > intr_pend > HLT > IMM-class > normal.
REQ-023 RUN branch_taken: pc_sel=1, pc_en=1, ifid_flush=1, stay RUN; a concurrent stall_in is ignored.
REQ-024 RUN stall_in: pc_en=0, ifid_en=0, stay RUN.
REQ-025 RUN intr_pend: pc_en=0, ifid_flush=1, go INT1.
REQ-026 RUN instr_valid and opcode==HLT_OPC: pc_en=0, ifid_flush=1, go HALT.
REQ-027 RUN instr_valid and opcode[6:5]==IMM_CLS: pc_en=mem_ready, ifid_en=0, go IMM when mem_ready=1.
REQ-028 RUN normal: pc_sel=0, pc_en=mem_ready, ifid_en=mem_ready.
REQ-029 IMM: imm_cycle=1, pc_en=mem_ready, ifid_en=mem_ready; ->RUN when mem_ready=1; branch_taken in IMM behaves as REQ-023 and returns RUN; intr deferred until RUN.
REQ-030 HALT: halted=1, pc_en=0, ifid_en=0; exit only to INT1 on intr_pend.
REQ-031 INT1: pc_save=1, pc_en=0, ifid_flush=1; unconditionally ->INT2 next cycle.
REQ-032 INT2: pc_sel=3, ifid_flush=1, pc_en=mem_ready; on mem_ready=1 assert intr_ack for that cycle and go RUN.
REQ-033 intr_pend SHALL set on intr rising edge (registered intr_q), clear on intr_ack; a new edge coincident with intr_ack re-sets it.
REQ-034 intr held level SHALL produce exactly one acknowledge.
REQ-035 Undefined state encoding SHALL recover to BOOT.

Reset
REQ-036 reset low SHALL asynchronously force state BOOT, intr_pend=0, intr_q=0.
REQ-037 Output values during reset: pc_sel=2, pc_en=0, ifid_en=0, ifid_flush=1, imm_cycle=0, pc_save=0, intr_ack=0, halted=0.
REQ-038 Reset mid-IMM or mid-INT SHALL abandon the sequence with no intr_ack.

Structure
REQ-039 State enum, pc_sel encodings and HLT_OPC/IMM_CLS constants SHALL live in shared package core_pkg, also used by CTRL_UNIT.
REQ-040 Interrupt edge detect/pending logic SHALL be sub-module intr_latch; FSM stays in fetch_seq.

Verification
REQ-041 Reset release, mem_ready=1 -> cycle1 pc_sel=2 pc_en=1; cycle2 RUN pc_sel=0.
REQ-042 opcode=7'b0100000 valid, mem_ready=1 -> next cycle imm_cycle=1, ifid_en held 0 during RUN cycle, then RUN.
REQ-043 opcode=7'b1100001 -> halted=1 next cycle, pc_en=0; intr pulse -> INT1 pc_save=1, INT2 pc_sel=3 intr_ack=1, halted=0.
REQ-044 branch_taken=1 and stall_in=1 same cycle -> pc_sel=1, pc_en=1, ifid_flush=1.
REQ-045 intr held high 20 cycles -> exactly one intr_ack.
REQ-046 reset asserted in INT2 with mem_ready=0 -> immediate BOOT outputs, no intr_ack.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch/control definitions: sequencer states, PC source encodings and
// the opcode constants that the fetch sequencer and control unit both decode.
package core_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_RUN  = 3'd1,
        ST_IMM  = 3'd2,
        ST_HALT = 3'd3,
        ST_INT1 = 3'd4,
        ST_INT2 = 3'd5
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_INC    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_RESET  = 2'd2,
        PC_SEL_INTR   = 2'd3
    } pc_sel_t;

    localparam int         OPC_W_DEF   = 7;
    localparam logic [6:0] HLT_OPC_DEF = 7'b1100001;
    localparam logic [1:0] IMM_CLS_DEF = 2'b01;

endpackage

// File: rtl/fetch_seq_if.sv
// Pipeline-side signals of the fetch sequencer: decode/execute status in,
// PC and IF/ID register controls out.
interface fetch_seq_if #(
    parameter int OPC_W = 7
);
    logic [OPC_W-1:0] opcode;
    logic             instr_valid;
    logic             mem_ready;
    logic             stall_in;
    logic             branch_taken;
    logic             intr;

    logic [1:0]       pc_sel;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             imm_cycle;
    logic             pc_save;
    logic             intr_ack;
    logic             halted;

    modport master (
        output opcode, instr_valid, mem_ready, stall_in, branch_taken, intr,
        input  pc_sel, pc_en, ifid_en, ifid_flush, imm_cycle, pc_save, intr_ack, halted
    );

    modport slave (
        input  opcode, instr_valid, mem_ready, stall_in, branch_taken, intr,
        output pc_sel, pc_en, ifid_en, ifid_flush, imm_cycle, pc_save, intr_ack, halted
    );
endinterface

// File: rtl/intr_latch.sv
// Turns the level interrupt request into a single pending flag: set on a rising
// edge, cleared by the acknowledge, so a held request is serviced only once.
module intr_latch (
    input  logic clk,
    input  logic reset,
    input  logic intr,
    input  logic intr_ack,
    output logic intr_pend
);
    logic intr_q;
    logic intr_rise;

    assign intr_rise = intr & ~intr_q;

    // NOTE: non-blocking assignments keep intr_q and intr_pend sampling the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intr_q    <= 1'b0;
            intr_pend <= 1'b0;
        end else begin
            intr_q    <= intr;
            intr_pend <= intr_rise | (intr_pend & ~intr_ack);
        end
    end
endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: boot vector fetch, two-word immediates, halt, interrupt
// entry and branch redirects, all decoded in the current cycle.
module fetch_seq
    import core_pkg::*;
#(
    parameter int               OPC_W   = OPC_W_DEF,
    parameter logic [OPC_W-1:0] HLT_OPC = HLT_OPC_DEF,
    parameter logic [1:0]       IMM_CLS = IMM_CLS_DEF
) (
    input logic        clk,
    input logic        reset,
    fetch_seq_if.slave bus
);
    fetch_state_t     state_q, state_d;
    pc_sel_t          pc_sel;
    logic             pc_en, ifid_en, ifid_flush, imm_cycle, pc_save, intr_ack, halted;
    logic             intr_pend;
    logic [OPC_W-1:0] opc;
    logic             is_halt, is_imm;

    assign opc     = bus.opcode;
    assign is_halt = bus.instr_valid && (opc == HLT_OPC);
    assign is_imm  = bus.instr_valid && (opc[OPC_W-1 -: 2] == IMM_CLS);

    intr_latch u_intr_latch (
        .clk       (clk),
        .reset     (reset),
        .intr      (bus.intr),
        .intr_ack  (intr_ack),
        .intr_pend (intr_pend)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path through the decode can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_sel     = PC_SEL_INC;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        imm_cycle  = 1'b0;
        pc_save    = 1'b0;
        intr_ack   = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pc_sel     = PC_SEL_RESET;
                ifid_flush = 1'b1;
                pc_en      = bus.mem_ready;
                if (bus.mem_ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.branch_taken) begin
                    pc_sel     = PC_SEL_BRANCH;
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                end else if (bus.stall_in) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                end else if (intr_pend) begin
                    ifid_flush = 1'b1;
                    state_d    = ST_INT1;
                end else if (is_halt) begin
                    ifid_flush = 1'b1;
                    state_d    = ST_HALT;
                end else if (is_imm) begin
                    // Hold IF/ID so the opcode stays visible while its immediate arrives.
                    pc_en = bus.mem_ready;
                    if (bus.mem_ready) state_d = ST_IMM;
                end else begin
                    pc_en   = bus.mem_ready;
                    ifid_en = bus.mem_ready;
                end
            end
            ST_IMM: begin
                imm_cycle = 1'b1;
                if (bus.branch_taken) begin
                    pc_sel     = PC_SEL_BRANCH;
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    pc_en   = bus.mem_ready;
                    ifid_en = bus.mem_ready;
                    if (bus.mem_ready) state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (intr_pend) state_d = ST_INT1;
            end
            ST_INT1: begin
                pc_save    = 1'b1;
                ifid_flush = 1'b1;
                state_d    = ST_INT2;
            end
            ST_INT2: begin
                pc_sel     = PC_SEL_INTR;
                ifid_flush = 1'b1;
                pc_en      = bus.mem_ready;
                intr_ack   = bus.mem_ready;
                if (bus.mem_ready) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase

        // While reset is held the PC must not load, even though BOOT would follow mem_ready.
        if (!reset) begin
            pc_sel     = PC_SEL_RESET;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
            imm_cycle  = 1'b0;
            pc_save    = 1'b0;
            intr_ack   = 1'b0;
            halted     = 1'b0;
        end
    end

    assign bus.pc_sel     = pc_sel;
    assign bus.pc_en      = pc_en;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.imm_cycle  = imm_cycle;
    assign bus.pc_save    = pc_save;
    assign bus.intr_ack   = intr_ack;
    assign bus.halted     = halted;
endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: a mode-level reference model checked every
// cycle, plus hand-computed spot checks on the key scenarios.
module tb_fetch_seq;

    localparam int M_BOOT = 0, M_RUN = 1, M_IMM = 2, M_HALT = 3, M_INT1 = 4, M_INT2 = 5;
    localparam logic [6:0] OPC_HLT = 7'b1100001;
    localparam logic [6:0] OPC_IMM = 7'b0100000;
    localparam logic [6:0] OPC_ALU = 7'b0000011;

    typedef struct packed {
        logic [1:0] sel;
        logic       pc_en;
        logic       ifid_en;
        logic       flush;
        logic       imm;
        logic       save;
        logic       ack;
        logic       halted;
    } outs_t;

    localparam outs_t RESET_OUTS = '{sel: 2'd2, flush: 1'b1, default: 1'b0};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   m_mode;
    logic m_pend, m_iq;

    fetch_seq_if #(.OPC_W(7)) bus ();

    fetch_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the fetch unit must do this cycle, from its mode and inputs.
    function automatic outs_t model(input int mode, input logic pend, input logic valid,
                                    input logic [6:0] opc, input logic mr, input logic stall,
                                    input logic br, output int nxt);
        outs_t o;
        logic  halt_instr, imm_instr;
        o          = '0;
        nxt        = mode;
        halt_instr = valid && (opc == OPC_HLT);
        imm_instr  = valid && (opc[6:5] == 2'b01);
        if (mode == M_BOOT) begin
            o.sel = 2'd2; o.flush = 1'b1; o.pc_en = mr;
            if (mr) nxt = M_RUN;
        end else if (mode == M_RUN) begin
            if (br)                begin o.sel = 2'd1; o.pc_en = 1'b1; o.flush = 1'b1; end
            else if (stall)        begin end
            else if (pend)         begin o.flush = 1'b1; nxt = M_INT1; end
            else if (halt_instr)   begin o.flush = 1'b1; nxt = M_HALT; end
            else if (imm_instr)    begin o.pc_en = mr; if (mr) nxt = M_IMM; end
            else                   begin o.pc_en = mr; o.ifid_en = mr; end
        end else if (mode == M_IMM) begin
            o.imm = 1'b1;
            if (br) begin o.sel = 2'd1; o.pc_en = 1'b1; o.flush = 1'b1; nxt = M_RUN; end
            else begin o.pc_en = mr; o.ifid_en = mr; if (mr) nxt = M_RUN; end
        end else if (mode == M_HALT) begin
            o.halted = 1'b1;
            if (pend) nxt = M_INT1;
        end else if (mode == M_INT1) begin
            o.save = 1'b1; o.flush = 1'b1; nxt = M_INT2;
        end else begin
            o.sel = 2'd3; o.flush = 1'b1; o.pc_en = mr; o.ack = mr;
            if (mr) nxt = M_RUN;
        end
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return '{sel: bus.pc_sel, pc_en: bus.pc_en, ifid_en: bus.ifid_en, flush: bus.ifid_flush,
                 imm: bus.imm_cycle, save: bus.pc_save, ack: bus.intr_ack, halted: bus.halted};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = M_BOOT; m_pend = 1'b0; m_iq = 1'b0;
        end else begin
            outs_t e;
            int    n;
            e      = model(m_mode, m_pend, bus.instr_valid, bus.opcode, bus.mem_ready,
                           bus.stall_in, bus.branch_taken, n);
            m_pend = (bus.intr & ~m_iq) | (m_pend & ~e.ack);
            m_iq   = bus.intr;
            m_mode = n;
        end
    end

    always @(negedge clk) begin
        outs_t e;
        int    n;
        e = reset ? model(m_mode, m_pend, bus.instr_valid, bus.opcode, bus.mem_ready,
                          bus.stall_in, bus.branch_taken, n)
                  : RESET_OUTS;
        check("cycle_outputs", 32'(dut_outs()), 32'(e));
        if (bus.intr_ack) ack_cnt++;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a0;
        reset = 1'b0;
        bus.opcode = OPC_ALU; bus.instr_valid = 1'b0; bus.mem_ready = 1'b1;
        bus.stall_in = 1'b0; bus.branch_taken = 1'b0; bus.intr = 1'b0;

        @(negedge clk);
        check("rst_pc_sel", bus.pc_sel, 2);
        check("rst_pc_en", bus.pc_en, 0);
        check("rst_flush", bus.ifid_flush, 1);

        // Reset release: BOOT fetches M[0], then RUN
        next(); reset = 1'b1;
        @(negedge clk); check("boot_pc_sel", bus.pc_sel, 2); check("boot_pc_en", bus.pc_en, 1);
        next();
        @(negedge clk); check("run_pc_sel", bus.pc_sel, 0); check("run_ifid_en", bus.ifid_en, 1);

        // Two-word instruction, immediate word delayed one cycle
        next(); bus.instr_valid = 1'b1; bus.opcode = OPC_IMM;
        @(negedge clk); check("imm_op_ifid_en", bus.ifid_en, 0); check("imm_op_pc_en", bus.pc_en, 1);
        next(); bus.instr_valid = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk); check("imm_wait_cycle", bus.imm_cycle, 1); check("imm_wait_pc_en", bus.pc_en, 0);
        next(); bus.mem_ready = 1'b1;
        @(negedge clk); check("imm_word_ifid_en", bus.ifid_en, 1);
        next();
        @(negedge clk); check("imm_done", bus.imm_cycle, 0);

        // Branch wins over a concurrent stall, then stall alone
        next(); bus.branch_taken = 1'b1; bus.stall_in = 1'b1;
        @(negedge clk);
        check("br_pc_sel", bus.pc_sel, 1); check("br_pc_en", bus.pc_en, 1); check("br_flush", bus.ifid_flush, 1);
        next(); bus.branch_taken = 1'b0;
        @(negedge clk); check("stall_pc_en", bus.pc_en, 0); check("stall_ifid_en", bus.ifid_en, 0);

        // Halt, then wake on an interrupt pulse
        next(); bus.stall_in = 1'b0; bus.instr_valid = 1'b1; bus.opcode = OPC_HLT;
        @(negedge clk); check("hlt_flush", bus.ifid_flush, 1); check("hlt_pc_en", bus.pc_en, 0);
        next(); bus.instr_valid = 1'b0;
        @(negedge clk); check("halted", bus.halted, 1);
        next(); bus.intr = 1'b1;
        next(); bus.intr = 1'b0;
        next();
        @(negedge clk); check("int1_save", bus.pc_save, 1); check("int1_halted", bus.halted, 0);
        next();
        @(negedge clk);
        check("int2_pc_sel", bus.pc_sel, 3); check("int2_ack", bus.intr_ack, 1); check("int2_halted", bus.halted, 0);

        // Interrupt raised while the immediate word is pending waits for RUN
        next(); bus.instr_valid = 1'b1; bus.opcode = OPC_IMM; bus.intr = 1'b1;
        next(); bus.instr_valid = 1'b0; bus.intr = 1'b0;
        @(negedge clk); check("imm_defer_cycle", bus.imm_cycle, 1); check("imm_defer_save", bus.pc_save, 0);
        next();
        @(negedge clk); check("defer_flush", bus.ifid_flush, 1); check("defer_pc_en", bus.pc_en, 0);
        repeat (3) next();

        // Level-held request acknowledged once
        a0 = ack_cnt;
        bus.intr = 1'b1;
        repeat (20) next();
        bus.intr = 1'b0;
        repeat (6) next();
        check("held_intr_acks", 32'(ack_cnt - a0), 1);

        // Reset while INT2 waits on memory: sequence abandoned, no acknowledge
        bus.intr = 1'b1;
        next(); bus.intr = 1'b0;
        next();
        next(); bus.mem_ready = 1'b0;
        @(negedge clk); check("int2_wait_sel", bus.pc_sel, 3); check("int2_wait_ack", bus.intr_ack, 0);
        a0 = ack_cnt;
        next(); reset = 1'b0;
        #1;
        check("rst_int2_sel", bus.pc_sel, 2); check("rst_int2_ack", bus.intr_ack, 0);
        check("rst_int2_save", bus.pc_save, 0);
        bus.mem_ready = 1'b1;
        repeat (2) next();
        reset = 1'b1;
        repeat (5) next();
        check("rst_no_ack", 32'(ack_cnt - a0), 0);
        @(negedge clk); check("rst_recover_sel", bus.pc_sel, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
